// File: rtl/flag_unit.sv
// flag_unit: byte-serial a-b compare producing registered Z/N/C/V flags.
module flag_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [3:0]  flags,
  output logic        flags_valid
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        carry_q, carry_d;
  logic [7:0]  zacc_q, zacc_d;
  logic        done_q, done_d;
  logic [3:0]  flags_q, flags_d;
  logic        valid_q, valid_d;
  logic [8:0]  sum;
  always_comb begin
    sum = {1'b0, a_q[{cnt_q, 3'b000} +: 8]} + {1'b0, ~b_q[{cnt_q, 3'b000} +: 8]} + {8'd0, carry_q};
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    flags_d = flags_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = CALC;
        a_d     = a;
        b_d     = b;
        carry_d = 1'b1;
        zacc_d  = 8'd0;
        cnt_d   = 2'd0;
      end
    end else begin
      carry_d = sum[8];
      zacc_d  = zacc_q | sum[7:0];
      cnt_d   = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        // final byte: sum[7] is r[31], sum[8] is the carry out of bit 31
        state_d = IDLE;
        done_d  = 1'b1;
        valid_d = 1'b1;
        flags_d = {~|(zacc_q | sum[7:0]), sum[7], sum[8], (a_q[31] ^ b_q[31]) & (sum[7] ^ a_q[31])};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      carry_q <= 1'b0;
      zacc_q  <= 8'd0;
      done_q  <= 1'b0;
      flags_q <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      done_q  <= done_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end
  assign busy        = (state_q == CALC);
  assign done        = done_q;
  assign flags       = flags_q;
  assign flags_valid = valid_q;
endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: randomized and directed checks of flag_unit against an arithmetic flag model.
module tb_flag_unit;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] a, b;
  logic        busy, done, flags_valid;
  logic [3:0]  flags;
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  exp_flags;
  logic        exp_valid;
  logic [31:0] ra, rb;
  bit          hold;

  always #5 clk = ~clk;

  flag_unit dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .flags(flags), .flags_valid(flags_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Flags from plain arithmetic: unsigned compare for C, signed range test for V.
  function automatic logic [3:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    longint      sd;
    r  = x - y;
    sd = longint'($signed(x)) - longint'($signed(y));
    return {r == 32'd0, r[31], x >= y, (sd > 64'sd2147483647) || (sd < -64'sd2147483648)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      tick;
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
      check("idle_flags", flags, exp_flags);
      check("idle_valid", flags_valid, exp_valid);
    end
  endtask

  task automatic do_cmp(input logic [31:0] ta, input logic [31:0] tb_, input bit noise, input bit hld);
    a = ta;
    b = tb_;
    start = 1'b1;
    tick;
    start = hld;
    check("acc_busy", busy, 1'b1);
    check("acc_done", done, 1'b0);
    repeat (3) begin
      if (noise) begin
        a = $urandom;
        b = $urandom;
        start = 1'($urandom % 2);
      end
      tick;
      check("calc_busy", busy, 1'b1);
      check("calc_done", done, 1'b0);
      check("calc_flags", flags, exp_flags);
    end
    start = hld;
    tick;
    exp_flags = model(ta, tb_);
    exp_valid = 1'b1;
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b0);
    check("done_flags", flags, exp_flags);
    check("done_valid", flags_valid, 1'b1);
  endtask

  task automatic abort(input logic [31:0] ta, input logic [31:0] tb_);
    a = ta;
    b = tb_;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    check("abort_busy_pre", busy, 1'b1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_flags = 4'd0;
    exp_valid = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_flags", flags, 4'd0);
    check("abort_valid", flags_valid, 1'b0);
    idle(5);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    exp_flags = 4'd0;
    exp_valid = 1'b0;
    repeat (2) tick;
    reset = 1'b0;
    idle(3);
    do_cmp(32'd5, 32'd5, 1'b0, 1'b0);
    check("eq_flags", flags, 4'b1010);
    idle(1);
    do_cmp(32'd3, 32'd5, 1'b0, 1'b0);
    check("lt_flags", flags, 4'b0100);
    idle(1);
    do_cmp(32'h8000_0000, 32'd1, 1'b0, 1'b0);
    check("ovf_flags", flags, 4'b0011);
    idle(1);
    do_cmp(32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("wrap_flags", flags, 4'b0000);
    idle(1);
    do_cmp(32'd100, 32'd7, 1'b1, 1'b0);
    idle(2);
    do_cmp(32'd1, 32'd2, 1'b0, 1'b1);
    do_cmp(32'd7, 32'd7, 1'b0, 1'b1);
    do_cmp(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(1);
    abort(32'd9, 32'd4);
    do_cmp(32'd9, 32'd4, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom % 5)
        0: rb = ra;
        1: rb = ra ^ 32'h8000_0000;
        2: rb = ra + 32'd1;
        default: ;
      endcase
      if ($urandom % 10 == 0) abort(ra, rb);
      else begin
        hold = ($urandom % 3 == 0);
        do_cmp(ra, rb, 1'b1, hold);
        if (!hold) idle($urandom_range(1, 2));
      end
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled only on clk rising edge.
REQ-004 start  input  1  request a compare of a and b; honoured only in IDLE.
REQ-005 a  input  32  minuend; sampled only on the edge that accepts start.
REQ-006 b  input  32  subtrahend; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while an accepted compare is in progress.
REQ-008 done  output  1  one-cycle pulse: flags updated for the latest compare.
REQ-009 flags  output  4  registered compare flags; bit3=Z, bit2=N, bit1=C, bit0=V (v c n z order, bit0 first); held between compares.
REQ-010 flags_valid  output  1  high once any compare has completed since reset.

Function
REQ-011 The block SHALL compute r = a - b as a + ~b + 1, byte-serial, one byte per clock, LSB byte first.
REQ-012 FSM states SHALL be IDLE and CALC only, plus a 2-bit byte counter cnt.
REQ-013 In IDLE with start=1 at an edge, the block SHALL latch a and b, set carry=1, zero-accumulator=0, cnt=0, and go to CALC; busy=1 from the next cycle.
REQ-014 In IDLE with start=0, the block SHALL hold all state; busy=0.
REQ-015 Each CALC edge SHALL add byte cnt of a, byte cnt of ~b and carry; store the 8-bit sum; carry = bit 8; OR the sum into the zero-accumulator; cnt increments.
REQ-016 On the CALC edge with cnt=3, the block SHALL write flags, pulse done=1 for the following cycle only, set flags_valid=1 and return to IDLE (busy=0).
REQ-017 Latency: done and the new flags SHALL appear exactly 4 edges after the edge that accepted start; throughput is one compare per 5 cycles.
REQ-018 Z SHALL be 1 iff all 32 result bits are 0.
REQ-019 N SHALL equal r[31].
REQ-020 C SHALL equal the final carry out of bit 31 (1 = no borrow, i.e. a >= b unsigned).
REQ-021 V SHALL be (a[31] != b[31]) and (r[31] != a[31]).
REQ-022 flags SHALL change only on the done edge or on reset.
REQ-023 start while busy=1 SHALL be ignored: no restart, no operand re-sample, no queueing.
REQ-024 start=1 held continuously SHALL start a new compare on the first IDLE edge after done, i.e. back-to-back every 5 cycles.
REQ-025 Changes on a or b during CALC SHALL not affect the result.
REQ-026 done and busy SHALL never be high in the same cycle.

Reset
REQ-027 On reset, the block SHALL set state=IDLE, cnt=0, busy=0, done=0, flags=4'b0000 and flags_valid=0.
REQ-028 Reset SHALL take priority over start and over any CALC step.
REQ-029 Reset mid-compare SHALL abort with no done pulse and no flags update.

Verification
REQ-030 Reset, then idle 3 cycles -> flags=0000, busy=0, done=0, flags_valid=0.
REQ-031 a=5, b=5, start -> done 4 edges later; flags=1010 (Z=1, C=1); flags_valid=1.
REQ-032 a=3, b=5 -> flags=0100 (N=1, C=0, V=0, Z=0); r=0xFFFFFFFE.
REQ-033 a=0x80000000, b=1 -> flags=0011 (V=1, C=1); then a=0, b=0xFFFFFFFF -> flags=0000.
REQ-034 start re-pulsed with new operands on the 2nd CALC cycle -> ignored; result is for the original operands; exactly one done.
REQ-035 Reset asserted on the 3rd CALC cycle -> no done; flags=0000; busy=0 the next cycle; a later start completes normally.
